// File: rtl/cordic_angle_sequencer.sv
// CORDIC z-path iteration controller: walks the arctan table, converts float32 degrees to fixed point,
// updates the angle residual and emits one rotation-direction bit per iteration. Option: CORDIC_ROUND_EN.
module cordic_angle_sequencer #(
    parameter int unsigned ITER  = 21,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ANG_W = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [ANG_W-1:0] angle_in,
    output logic [7:0]              i,
    input  logic [31:0]             atan_in,
    output logic                    dir,
    output logic                    dir_valid,
    output logic signed [ANG_W-1:0] z_out,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Float exponent at which the mantissa lands unshifted in the fixed-point frame.
    localparam int unsigned BIAS = 127 - FRAC + 23;

    state_t                  state_q;
    logic [7:0]              i_q;
    logic                    dir_q;
    logic                    dv_q;
    logic signed [ANG_W-1:0] z_q;
    logic signed [ANG_W-1:0] z_d;
    logic                    busy_q;
    logic                    done_q;

    logic [7:0]              exp_w;
    logic [23:0]             man_w;
    logic [ANG_W+23:0]       shl_w;
    logic [23:0]             shr_w;
    logic [ANG_W-1:0]        atan_fix;
    int unsigned             lsh;
    int unsigned             rsh;
    logic                    sign_unused;
`ifdef CORDIC_ROUND_EN
    logic [4:0]              ridx;
    logic                    rnd_bit;
`endif

    assign sign_unused = atan_in[31];

    always_comb begin
        exp_w    = atan_in[30:23];
        man_w    = {1'b1, atan_in[22:0]};
        shl_w    = '0;
        shr_w    = '0;
        atan_fix = '0;
        lsh      = 0;
        rsh      = 0;
`ifdef CORDIC_ROUND_EN
        ridx     = '0;
        rnd_bit  = 1'b0;
`endif
        if (exp_w == 8'd0) begin
            atan_fix = '0;
        end else if (32'(exp_w) >= BIAS) begin
            lsh = 32'(exp_w) - BIAS;
            if (lsh < ANG_W) begin
                shl_w    = {{ANG_W{1'b0}}, man_w} << lsh;
                atan_fix = shl_w[ANG_W-1:0];
            end
        end else begin
            rsh = BIAS - 32'(exp_w);
            if (rsh < 24)
                shr_w = man_w >> rsh;
`ifdef CORDIC_ROUND_EN
            // Half-up: the first discarded bit is added back after the shift.
            if (rsh <= 24) begin
                ridx    = 5'(rsh - 1);
                rnd_bit = man_w[ridx];
            end
            atan_fix = ANG_W'(shr_w) + ANG_W'(rnd_bit);
`else
            atan_fix = ANG_W'(shr_w);
`endif
        end
    end

    always_comb begin
        z_d = z_q;
        if (z_q[ANG_W-1])
            z_d = z_q + $signed(atan_fix);
        else
            z_d = z_q - $signed(atan_fix);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            dir_q   <= 1'b0;
            dv_q    <= 1'b0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dv_q   <= 1'b0;
                    done_q <= 1'b0;
                    i_q    <= '0;
                    if (start) begin
                        z_q     <= angle_in;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    dir_q <= ~z_q[ANG_W-1];
                    z_q   <= z_d;
                    dv_q  <= 1'b1;
                    if (i_q == 8'(ITER - 1)) begin
                        i_q     <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        i_q <= i_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i         = i_q;
    assign dir       = dir_q;
    assign dir_valid = dv_q;
    assign z_out     = z_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
